// File: rtl/bcd_seg_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan_if
//
// Bundles the data-side and display-side signals of the two-digit
// multiplexed seven-segment driver.
//
//   bcd_in  [7:0]  packed BCD byte, [7:4] tens and [3:0] ones
//   load           capture strobe for bcd_in
//   seg     [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   an      [1:0]  digit enables, active-low: an[0] ones, an[1] tens
//   invalid        latched byte holds a nibble greater than 9
//
// The master modport is the side that produces BCD values and reads the
// display pins. The slave modport is the driver itself.
// ---------------------------------------------------------------------------
interface bcd_seg_scan_if;
    logic [7:0] bcd_in;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       invalid;

    modport master (
        output bcd_in,
        output load,
        input  seg,
        input  an,
        input  invalid
    );

    modport slave (
        input  bcd_in,
        input  load,
        output seg,
        output an,
        output invalid
    );
endinterface

// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
//
// Two-digit multiplexed seven-segment display driver. It latches a packed
// BCD byte on a load strobe. It then time-multiplexes the ones and tens
// digits onto one shared active-low segment bus. A blank phase follows
// each digit so that the previous digit does not ghost onto the next one.
// Scan order: ones, gap, tens, gap. Each phase lasts DIV clock cycles.
//
// Parameters
//   DIV    clk cycles per scan phase (minimum 2)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd_seg_scan_if.slave (bcd_in, load in; seg, an, invalid out)
//
// Optional feature
//   BCD_SCAN_LZB_EN  When defined, the tens digit stays dark if it is 0.
//                    The length of the tens phase does not change.
// ---------------------------------------------------------------------------
module bcd_seg_scan #(
    parameter int DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_seg_scan_if.slave       bus
);

    localparam int               CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_NONE   = 2'b11;
    localparam logic [1:0] AN_ONES   = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    typedef enum logic [1:0] {
        S_ONES,
        S_GAP0,
        S_TENS,
        S_GAP1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       bcd_q, bcd_d;
    logic             invalid_q, invalid_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             tick;

    // Active-low decode. A non-decimal nibble is shown as a lone g segment
    // (a dash), so a bad input is visible on the display.
    function automatic logic [6:0] decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    assign tick = (cnt_q == CNT_MAX);

    // Next-state logic for the prescaler, the scan FSM, the registered
    // display outputs and the capture register. The display pattern is
    // worked out only on the tick edge. It uses the state being entered
    // and the byte held before that edge. Because of this, a load in the
    // middle of a phase, or on the tick edge itself, cannot disturb the
    // digit currently being shown.
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        state_d   = state_q;
        an_d      = an_q;
        seg_d     = seg_q;
        bcd_d     = bcd_q;
        invalid_d = invalid_q;

        if (tick) begin
            case (state_q)
                S_ONES:  state_d = S_GAP0;
                S_GAP0:  state_d = S_TENS;
                S_TENS:  state_d = S_GAP1;
                default: state_d = S_ONES;
            endcase

            case (state_d)
                S_ONES: begin
                    an_d  = AN_ONES;
                    seg_d = decode(bcd_q[3:0]);
                end
                S_TENS: begin
`ifdef BCD_SCAN_LZB_EN
                    if (bcd_q[7:4] == 4'd0) begin
                        an_d  = AN_NONE;
                        seg_d = SEG_BLANK;
                    end else begin
                        an_d  = AN_TENS;
                        seg_d = decode(bcd_q[7:4]);
                    end
`else
                    an_d  = AN_TENS;
                    seg_d = decode(bcd_q[7:4]);
`endif
                end
                default: begin
                    an_d  = AN_NONE;
                    seg_d = SEG_BLANK;
                end
            endcase
        end

        if (bus.load) begin
            bcd_d     = bus.bcd_in;
            invalid_d = (bus.bcd_in[7:4] > 4'd9) | (bus.bcd_in[3:0] > 4'd9);
        end
    end

    // State register. Reset parks the scan in the last gap with the display
    // dark. The first tick then enters the ones phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            state_q   <= S_GAP1;
            bcd_q     <= 8'h00;
            invalid_q <= 1'b0;
            an_q      <= AN_NONE;
            seg_q     <= SEG_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            invalid_q <= invalid_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan
//
// Self-checking bench for bcd_seg_scan with DIV=4. The reference model is
// written in terms of elapsed clock edges. Every DIV-th edge after reset
// enters phase ((edge/DIV)-1) mod 4: ones, gap, tens, gap. The model shows
// the byte held before that edge. Directed steps cover the listed display
// scenarios. A randomized stretch then runs against the same model.
// Follows BCD_SCAN_LZB_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

    localparam int DIV = 4;
    localparam logic [6:0] DIGIT_TAB [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    int         m_edges;
    int         m_bcd;
    logic       m_inv;
    logic [1:0] m_an;
    logic [6:0] m_seg;

    bcd_seg_scan_if bus_if ();

    bcd_seg_scan #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Model digit pattern: a table lookup for 0..9, and a dash otherwise.
    function automatic logic [6:0] modelDigit(input int v);
        return (v > 9) ? 7'h3F : DIGIT_TAB[v];
    endfunction

    // Puts the model back into the dark, idle state that reset produces.
    task automatic modelReset();
        m_edges = 0;
        m_bcd   = 0;
        m_inv   = 1'b0;
        m_an    = 2'b11;
        m_seg   = 7'h7F;
    endtask

    // Advances the model by one rising edge with the given load inputs.
    task automatic modelEdge(input logic ld, input logic [7:0] val);
        int phase;
        m_edges++;
        if (m_edges % DIV == 0) begin
            phase = ((m_edges / DIV) - 1) % 4;
            if (phase == 0) begin
                m_an  = 2'b10;
                m_seg = modelDigit(m_bcd % 16);
            end else if (phase == 2) begin
`ifdef BCD_SCAN_LZB_EN
                if (m_bcd / 16 == 0) begin
                    m_an  = 2'b11;
                    m_seg = 7'h7F;
                end else begin
                    m_an  = 2'b01;
                    m_seg = modelDigit(m_bcd / 16);
                end
`else
                m_an  = 2'b01;
                m_seg = modelDigit(m_bcd / 16);
`endif
            end else begin
                m_an  = 2'b11;
                m_seg = 7'h7F;
            end
        end
        if (ld) begin
            m_bcd = int'(val);
            m_inv = (val / 16 > 9) || (val % 16 > 9);
        end
    endtask

    // Compares all three outputs against the model.
    task automatic checkOutput(input string tag);
        checks++;
        assert (bus_if.an === m_an) else begin
            errors++;
            $error("[TB] FAIL %s an observed %b expected %b", tag, bus_if.an, m_an);
        end
        checks++;
        assert (bus_if.seg === m_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg observed %h expected %h", tag, bus_if.seg, m_seg);
        end
        checks++;
        assert (bus_if.invalid === m_inv) else begin
            errors++;
            $error("[TB] FAIL %s invalid observed %b expected %b", tag, bus_if.invalid, m_inv);
        end
    endtask

    // Compares the segment bus against a fixed value taken from a scenario.
    task automatic checkSeg(input string tag, input logic [6:0] want);
        checks++;
        assert (bus_if.seg === want) else begin
            errors++;
            $error("[TB] FAIL %s seg observed %h expected %h", tag, bus_if.seg, want);
        end
    endtask

    // Drives one clock cycle of inputs, steps the model, then checks 1 time
    // unit after the edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] val, input string tag);
        bus_if.load   = ld;
        bus_if.bcd_in = val;
        @(posedge clk);
        modelEdge(ld, val);
        #1;
        bus_if.load = 1'b0;
        checkOutput(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, tag);
    endtask

    // Idles until the model edge count satisfies (edges mod 16) == target.
    // The loop is bounded to one frame.
    task automatic idleUntil(input int target, input string tag);
        for (int i = 0; i < 16 && (m_edges % 16) != target; i++)
            applyStimulus(1'b0, 8'h00, tag);
    endtask

    // Asserts reset away from the clock edge and checks the blank display
    // right away. Reset is held across one rising edge and then released
    // on a falling edge.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        modelReset();
        #2;
        checkOutput(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus_if.load   = 1'b0;
        bus_if.bcd_in = 8'h00;
        modelReset();
        #1;
        doReset("reset");

        // Release: ones phase showing 0 on the 4th edge.
        idle(4, "first_ones");
        checkSeg("first_ones_zero", 7'h40);

        // 15: ones shows 5, tens shows 1.
        applyStimulus(1'b1, 8'h15, "load15");
        idle(20, "scan15");

        // 1C: flagged invalid on the next edge, with a dash on the ones digit.
        applyStimulus(1'b1, 8'h1C, "load1C");
        checks++;
        assert (bus_if.invalid === 1'b1) else begin
            errors++;
            $error("[TB] FAIL inv1C invalid observed %b expected %b", bus_if.invalid, 1'b1);
        end
        idle(17, "scan1C");
        applyStimulus(1'b1, 8'h42, "load42");
        idle(17, "scan42");

        // 07: the tens digit is dark with blanking, or shows 0 without it.
        applyStimulus(1'b1, 8'h07, "load07");
        idleUntil(12, "scan07");
`ifdef BCD_SCAN_LZB_EN
        checkSeg("tens07", 7'h7F);
`else
        checkSeg("tens07", 7'h40);
`endif
        idle(8, "scan07b");

        // Load 98 on the edge entering ones, with 15 held before it.
        applyStimulus(1'b1, 8'h15, "pre15");
        for (int i = 0; i < 16 && ((m_edges + 1) % 16) != 4; i++)
            applyStimulus(1'b0, 8'h00, "seek_ones");
        applyStimulus(1'b1, 8'h98, "coincident");
        checkSeg("coincident_ones_old", 7'h12);
        idleUntil(12, "to_tens98");
        checkSeg("tens98", 7'h10);
        idleUntil(4, "to_ones98");
        checkSeg("ones98", 7'h00);

        // Reset in the middle of the tens phase.
        idleUntil(13, "to_mid_tens");
        doReset("mid_reset");
        idle(4, "after_reset");
        checkSeg("after_reset_ones", 7'h40);

        // Randomized loads, including non-decimal nibbles and back-to-back
        // strobes.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)), "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
